// File: rtl/acc_seq_pkg.sv
// Shared types and helpers for the sequenced shift-add multiplier.
package acc_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        RUN  = 2'b10,
        DONE = 2'b11
    } state_t;

    // Step counter must be able to hold W-1.
    function automatic int unsigned cnt_w(input int unsigned w);
        return int'($clog2(w)) + 1;
    endfunction

endpackage

// File: rtl/acc_shift_add_seq_if.sv
// Start/Busy/Done handshake and operand/product bus of the shift-add multiplier.
interface acc_shift_add_seq_if #(
    parameter int unsigned W = 4
);
    logic             Start;
    logic [W-1:0]     Multiplicand;
    logic [W-1:0]     Multiplier;
    logic             Busy;
    logic             Done;
    logic [2*W-1:0]   Produto;

    modport master (
        output Start, Multiplicand, Multiplier,
        input  Busy, Done, Produto
    );

    modport slave (
        input  Start, Multiplicand, Multiplier,
        output Busy, Done, Produto
    );
endinterface

// File: rtl/acc_dp.sv
// Accumulator datapath: {partial product, multiplier} register, adder and shifter.
// SIGNED_MUL_EN selects two's-complement operands with a final subtract step.
module acc_dp #(
    parameter int unsigned W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ld,
    input  logic             step,
    input  logic             last,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic [2*W-1:0]   prod_c
);
    localparam int unsigned AW = 2*W + 1;

    logic [AW-1:0] acc_q;
    logic [AW-1:0] acc_nxt;
    logic [W-1:0]  mcand_q;
    logic [W:0]    hi;
    logic [W:0]    addend;
    logic [W:0]    sum;

    // One combined add-and-shift; acc[2W] keeps the carry until the shift.
    always_comb begin
        hi = acc_q[AW-1:W];
`ifdef SIGNED_MUL_EN
        addend  = acc_q[0] ? {mcand_q[W-1], mcand_q} : '0;
        sum     = last ? (hi - addend) : (hi + addend);
        acc_nxt = {sum[W], sum, acc_q[W-1:1]};
`else
        addend  = acc_q[0] ? {1'b0, mcand_q} : '0;
        sum     = hi + addend;
        acc_nxt = {1'b0, sum, acc_q[W-1:1]};
`endif
    end

`ifndef SIGNED_MUL_EN
    logic unused_last;
    assign unused_last = last;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q   <= '0;
            mcand_q <= '0;
        end else if (ld) begin
            mcand_q <= a;
            acc_q   <= {{(W+1){1'b0}}, b};
        end else if (step) begin
            acc_q   <= acc_nxt;
        end
    end

    // Post-shift value, so the product can be captured on the last step edge.
    assign prod_c = acc_nxt[2*W-1:0];

endmodule

// File: rtl/acc_shift_add_seq.sv
// Sequenced shift-add multiplier: FSM, step counter and registered Busy/Done/Produto.
// Optional macro SIGNED_MUL_EN switches the datapath to two's-complement operands.
module acc_shift_add_seq
    import acc_seq_pkg::*;
#(
    parameter int unsigned W     = 4,
    parameter int unsigned CNT_W = cnt_w(W)
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    acc_shift_add_seq_if.slave   bus
);
    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               ld_c;
    logic               step_c;
    logic               last_c;
    logic [2*W-1:0]     prod_c;
    logic               busy_q;
    logic               done_q;
    logic [2*W-1:0]     produto_q;

    acc_dp #(.W(W)) u_dp (
        .clk    (Clk),
        .rst_n  (Rst_n),
        .ld     (ld_c),
        .step   (step_c),
        .last   (last_c),
        .a      (bus.Multiplicand),
        .b      (bus.Multiplier),
        .prod_c (prod_c)
    );

    // Next-state and datapath strobes; Start only matters in IDLE.
    always_comb begin
        state_d = state_q;
        ld_c    = 1'b0;
        step_c  = 1'b0;
        last_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.Start) begin
                    ld_c    = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: state_d = RUN;
            RUN: begin
                step_c = 1'b1;
                if (cnt_q == CNT_W'(W - 1)) begin
                    last_c  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (ld_c) begin
                cnt_q <= '0;
            end else if (step_c) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // Outputs follow the next state so they line up with the state they describe.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            produto_q <= '0;
        end else begin
            busy_q <= (state_d == LOAD) || (state_d == RUN);
            done_q <= (state_d == DONE);
            if (last_c) begin
                produto_q <= prod_c;
            end
        end
    end

    assign bus.Busy    = busy_q;
    assign bus.Done    = done_q;
    assign bus.Produto = produto_q;

endmodule
